// File: rtl/ms_uart_apb_seq.sv
// ms_uart_apb_seq: APB master sequencer that owns one ms_uart_apb slave.
// It writes the init sequence, polls RIS, then pushes TX bytes and drains RX
// bytes into a one-entry holding register. TX and RX share the bus by round-robin.
// Optional feature macro: MS_UART_SEQ_TIMEOUT_EN adds a PREADY timeout and a sticky err flag.
module ms_uart_apb_seq #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned TO_W      = 8
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        enable,
    input  logic [15:0] prescale,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic        PREADY,
    input  logic [31:0] PRDATA,
    output logic        running,
    output logic        err
);
    localparam logic [31:0] A_DATA     = 32'h000;
    localparam logic [31:0] A_PRESCALE = 32'h004;
    localparam logic [31:0] A_CTRL     = 32'h100;
    localparam logic [31:0] A_RIS      = 32'h200;
    localparam logic [31:0] A_IM       = 32'h208;
    localparam logic [31:0] A_ICR      = 32'h20C;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_POLL, S_TX_WR, S_RX_RD, S_STOP} state_t;
    typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

    state_t      st, st_nx;
    phase_t      ph, ph_nx;
    logic [2:0]  init_idx, init_idx_nx;
    logic        rr_rx, rr_rx_nx;           // 1: RX wins the next tie
    logic        running_nx, rx_valid_nx;
    logic [7:0]  rx_data_nx;
    logic [31:0] addr_q, addr_nx, wdata_q, wdata_nx;
    logic        wr_q, wr_nx;
    logic        rx_ok, tx_ok, to_abort;
    logic        unused_prdata;

    assign PSEL     = (ph != PH_GAP);
    assign PENABLE  = (ph == PH_ACCESS);
    assign PWRITE   = wr_q;
    assign PADDR    = addr_q;
    assign PWDATA   = wdata_q;
    assign tx_ready = (st == S_TX_WR) && (ph == PH_ACCESS) && PREADY;

    // RIS decode, valid only on the PREADY cycle of a RIS read
    assign rx_ok = !PRDATA[4] && (!rx_valid || rx_ready);
    assign tx_ok = tx_valid && !PRDATA[0];
    assign unused_prdata = ^PRDATA[31:8];

    // state, bus request and holding registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            st       <= S_IDLE;
            ph       <= PH_GAP;
            init_idx <= '0;
            rr_rx    <= 1'b1;
            running  <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            st       <= st_nx;
            ph       <= ph_nx;
            init_idx <= init_idx_nx;
            rr_rx    <= rr_rx_nx;
            running  <= running_nx;
            rx_valid <= rx_valid_nx;
            rx_data  <= rx_data_nx;
            addr_q   <= addr_nx;
            wdata_q  <= wdata_nx;
            wr_q     <= wr_nx;
        end
    end

    // sequencing: a new transfer is launched only from the PSEL=0 gap cycle
    always_comb begin
        st_nx       = st;
        ph_nx       = ph;
        init_idx_nx = init_idx;
        rr_rx_nx    = rr_rx;
        running_nx  = running;
        rx_valid_nx = rx_valid && !rx_ready;
        rx_data_nx  = rx_data;
        addr_nx     = addr_q;
        wdata_nx    = wdata_q;
        wr_nx       = wr_q;
        case (ph)
            PH_GAP: begin
                case (st)
                    S_IDLE: if (enable) begin
                        st_nx       = S_INIT;
                        init_idx_nx = '0;
                    end
                    S_INIT: begin
                        if (!enable) st_nx = S_STOP;
                        else begin
                            ph_nx = PH_SETUP;
                            wr_nx = 1'b1;
                            case (init_idx)
                                3'd0:    begin addr_nx = BASE_ADDR + A_CTRL;     wdata_nx = 32'h0;            end
                                3'd1:    begin addr_nx = BASE_ADDR + A_PRESCALE; wdata_nx = {16'h0, prescale}; end
                                3'd2:    begin addr_nx = BASE_ADDR + A_IM;       wdata_nx = 32'h0;            end
                                3'd3:    begin addr_nx = BASE_ADDR + A_ICR;      wdata_nx = 32'h3F;           end
                                default: begin addr_nx = BASE_ADDR + A_CTRL;     wdata_nx = 32'h1;            end
                            endcase
                        end
                    end
                    S_POLL: begin
                        if (!enable) st_nx = S_STOP;
                        else begin
                            ph_nx   = PH_SETUP;
                            wr_nx   = 1'b0;
                            addr_nx = BASE_ADDR + A_RIS;
                        end
                    end
                    // byte was committed at grant; tx_data is captured here
                    S_TX_WR: begin
                        ph_nx    = PH_SETUP;
                        wr_nx    = 1'b1;
                        addr_nx  = BASE_ADDR + A_DATA;
                        wdata_nx = {24'h0, tx_data};
                    end
                    S_RX_RD: begin
                        ph_nx   = PH_SETUP;
                        wr_nx   = 1'b0;
                        addr_nx = BASE_ADDR + A_DATA;
                    end
                    default: begin
                        ph_nx    = PH_SETUP;
                        wr_nx    = 1'b1;
                        addr_nx  = BASE_ADDR + A_CTRL;
                        wdata_nx = 32'h0;
                    end
                endcase
            end
            PH_SETUP: ph_nx = PH_ACCESS;
            default: begin
                if (PREADY) begin
                    ph_nx = PH_GAP;
                    case (st)
                        S_INIT: begin
                            if (!enable) st_nx = S_STOP;
                            else if (init_idx == 3'd4) begin
                                st_nx      = S_POLL;
                                running_nx = 1'b1;
                            end else init_idx_nx = init_idx + 3'd1;
                        end
                        S_POLL: begin
                            if (!enable) st_nx = S_STOP;
                            else if (rx_ok && (!tx_ok || rr_rx)) begin
                                st_nx    = S_RX_RD;
                                rr_rx_nx = 1'b0;
                            end else if (tx_ok) begin
                                st_nx    = S_TX_WR;
                                rr_rx_nx = 1'b1;
                            end
                        end
                        S_TX_WR: st_nx = S_POLL;
                        S_RX_RD: begin
                            st_nx       = S_POLL;
                            rx_valid_nx = 1'b1;
                            rx_data_nx  = PRDATA[7:0];
                        end
                        S_STOP: begin
                            st_nx      = S_IDLE;
                            running_nx = 1'b0;
                        end
                        default: st_nx = S_IDLE;
                    endcase
                end else if (to_abort) begin
                    ph_nx = PH_GAP;
                    if (st == S_INIT) begin
                        st_nx      = S_IDLE;
                        running_nx = 1'b0;
                    end else st_nx = S_POLL;
                end
            end
        endcase
    end

`ifdef MS_UART_SEQ_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    // abort on the (2^TO_W-1)th ACCESS cycle without PREADY
    assign to_abort = (ph == PH_ACCESS) && !PREADY && (to_cnt == TO_LAST);
    assign err      = err_q;

    // ACCESS cycle counter and sticky error flag
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (ph == PH_ACCESS) ? to_cnt + 1'b1 : '0;
            if (to_abort) err_q <= 1'b1;
        end
    end
`else
    localparam int unsigned TO_W_UNUSED = TO_W;
    assign to_abort = 1'b0;
    assign err      = 1'b0;
`endif
endmodule

// File: tb/tb_ms_uart_apb_seq.sv
// Bench for ms_uart_apb_seq: a behavioural UART slave with TX->RX loopback,
// a per-cycle protocol/data checker and directed stimulus.
module tb_ms_uart_apb_seq;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] INIT_A [5] = '{BASE + 32'h100, BASE + 32'h004, BASE + 32'h208, BASE + 32'h20C, BASE + 32'h100};
    localparam logic [31:0] INIT_D [5] = '{32'h0, 32'h2, 32'h0, 32'h3F, 32'h1};
    localparam logic [7:0]  LIT [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                                         8'hA5, 8'h5A, 8'hC3, 8'h3C};

    logic        PCLK = 0, PRESETn = 0, enable = 0, tx_valid = 0, rx_ready = 0;
    logic [15:0] prescale = 16'd2;
    logic [7:0]  tx_data = 8'h0;
    logic        tx_ready, rx_valid, running, err, PSEL, PENABLE, PWRITE, PREADY;
    logic [7:0]  rx_data;
    logic [31:0] PADDR, PWDATA, PRDATA;
    int checks = 0, failures = 0;

    ms_uart_apb_seq #(.BASE_ADDR(BASE), .TO_W(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .enable(enable), .prescale(prescale),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .running(running), .err(err));

    always #5 PCLK = ~PCLK;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- slave: loopback UART register model ----------------
    logic [7:0] rxmem [16];
    logic [3:0] rd_p = 0, wr_p = 0;
    int         acc_cnt = 0, stretch = 0;
    logic       stuck = 0, tx_full = 0;

    assign PREADY = PSEL && PENABLE && !stuck && (acc_cnt >= stretch);

    always_comb begin
        PRDATA = 32'h0;
        if (PADDR == BASE + 32'h200) PRDATA = {27'h0, (rd_p == wr_p), 3'h0, tx_full};
        else if (PADDR == BASE)      PRDATA = {24'h0, rxmem[rd_p]};
    end

    always @(posedge PCLK) begin
        acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
        if (PSEL && PENABLE && PREADY && PADDR == BASE) begin
            if (PWRITE) begin
                rxmem[wr_p] <= PWDATA[7:0];
                wr_p <= wr_p + 4'd1;
            end else if (rd_p != wr_p) rd_p <= rd_p + 4'd1;
        end
    end

    // ---------------- per-cycle checker with behavioural model ----------------
    logic        in_acc = 0, done_prev = 0, ris_ok = 0, m_rxv = 0, m_run = 0, s_wr = 0;
    logic [7:0]  m_rxd = 0;
    logic [31:0] s_addr = 0, s_wdata = 0;
    int          acc_len = 0, last_dwr_len = 0, abort_len = 0, n_data_wr = 0, n_ris = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  rcv [$];
    logic [31:0] wl_a [$], wl_d [$];

    always @(negedge PCLK) begin
        logic nv, fin;
        logic [7:0] e;
        if (!PRESETn) begin
            in_acc <= 0; done_prev <= 0; ris_ok <= 0; m_rxv <= 0; m_run <= 0; acc_len <= 0;
        end else begin
            fin = PSEL && PENABLE && PREADY;
            if (done_prev) check("apb_gap", PSEL, 0);
            if (PSEL && !PENABLE) begin
                check("setup_from_idle", in_acc, 0);
                in_acc <= 1; acc_len <= 0; s_addr <= PADDR; s_wdata <= PWDATA; s_wr <= PWRITE;
                if (PWRITE && PADDR == BASE) begin
                    check("data_wr_after_ris_not_full", ris_ok, 1);
                    check("tx_pwdata", PWDATA, {24'h0, tx_data});
                end
                if (!PWRITE && PADDR == BASE) check("rx_rd_holding_empty", rx_valid, 0);
            end
            if (PSEL && PENABLE) begin
                check("access_after_setup", in_acc, 1);
                check("apb_stable", (PADDR == s_addr && PWDATA == s_wdata && PWRITE == s_wr), 1);
                acc_len <= acc_len + 1;
            end
            check("tx_ready", tx_ready, fin && PWRITE && PADDR == BASE);
            check("running", running, m_run);
`ifndef MS_UART_SEQ_TIMEOUT_EN
            check("err_tied", err, 0);
`endif
            check("rx_valid", rx_valid, m_rxv);
            if (m_rxv) check("rx_data", rx_data, m_rxd);
            nv = m_rxv;
            if (rx_valid && rx_ready) begin
                nv = 0;
                if (exp_q.size() == 0) check("rx_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rx_order", rx_data, e);
                end
                rcv.push_back(rx_data);
            end
            if (fin) begin
                in_acc <= 0;
                if (PWRITE && PADDR == BASE) begin
                    n_data_wr <= n_data_wr + 1; ris_ok <= 0; exp_q.push_back(tx_data);
                    last_dwr_len <= acc_len + 1;
                end else if (PWRITE) begin
                    wl_a.push_back(PADDR); wl_d.push_back(PWDATA);
                    if (PADDR == BASE + 32'h100) m_run <= PWDATA[0];
                end else if (PADDR == BASE + 32'h200) begin
                    ris_ok <= !PRDATA[0]; n_ris <= n_ris + 1;
                end else if (PADDR == BASE) begin
                    nv = 1; m_rxd <= PRDATA[7:0];
                end
            end else if (!PSEL && in_acc) begin
                in_acc <= 0; abort_len <= acc_len;
            end
            m_rxv <= nv;
            done_prev <= fin;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        logic got;
        got = 0;
        @(posedge PCLK); #1; tx_valid = 1; tx_data = b;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge PCLK); got = tx_ready;
        end
        check("send_accepted", got, 1);
        @(posedge PCLK); #1; tx_valid = 0;
    endtask

    task automatic wait_rcv(input int n);
        for (int i = 0; i < 400 && rcv.size() < n; i++) @(negedge PCLK);
        check("rcv_count", rcv.size(), n);
    endtask

    initial begin
        int n0, r0, w0;
        repeat (3) @(negedge PCLK);
        check("rst_psel", PSEL, 0);      check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);  check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);  check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0); check("rst_rx_data", rx_data, 0);
        check("rst_running", running, 0);   check("rst_err", err, 0);

        @(posedge PCLK); #1; PRESETn = 1; enable = 1; rx_ready = 1;
        for (int i = 0; i < 200 && running !== 1; i++) @(negedge PCLK);
        check("init_running", running, 1);
        check("init_count", wl_a.size(), 5);
        for (int k = 0; k < 5 && k < wl_a.size(); k++) begin
            check("init_addr", wl_a[k], INIT_A[k]);
            check("init_data", wl_d[k], INIT_D[k]);
        end

        // streaming with a free-running consumer
        for (int b = 1; b <= 8; b++) send(8'(8'h11 * b));
        wait_rcv(8);

        // consumer stalled: holding keeps 0xA5, 0x5A stays in the slave
        @(posedge PCLK); #1; rx_ready = 0;
        send(8'hA5);
        send(8'h5A);
        repeat (30) @(negedge PCLK);
        check("hold_valid", rx_valid, 1);
        check("hold_data", rx_data, 8'hA5);
        check("hold_slave_not_drained", (rd_p != wr_p), 1);
        @(posedge PCLK); #1; rx_ready = 1;
        wait_rcv(10);

        // stretched PREADY
        stretch = 3;
        send(8'hC3);
        wait_rcv(11);
        check("stretch_penable_len", last_dwr_len, 4);
        stretch = 0;

        // TX full blocks DATA writes while polling continues
        @(posedge PCLK); #1; tx_full = 1; tx_valid = 1; tx_data = 8'h3C;
        n0 = n_data_wr; r0 = n_ris;
        repeat (40) @(negedge PCLK);
        check("full_no_data_wr", n_data_wr, n0);
        check("full_polls", (n_ris - r0 >= 3), 1);
        @(posedge PCLK); #1; tx_full = 0;
        for (int i = 0; i < 100 && tx_ready !== 1; i++) @(negedge PCLK);
        check("full_release_wr", tx_ready, 1);
        @(posedge PCLK); #1; tx_valid = 0;
        wait_rcv(12);
        for (int k = 0; k < 12; k++)
            check("stream_byte", (k < rcv.size()) ? rcv[k] : 8'hxx, LIT[k]);

`ifdef MS_UART_SEQ_TIMEOUT_EN
        check("to_err_before", err, 0);
        @(posedge PCLK); #1; stuck = 1;
        for (int i = 0; i < 300 && err !== 1; i++) @(negedge PCLK);
        check("to_err", err, 1);
        @(negedge PCLK);
        check("to_access_len", abort_len, 15);
        @(posedge PCLK); #1; stuck = 0;
        send(8'hE7);
        wait_rcv(13);
        check("to_recover_byte", (rcv.size() > 12) ? rcv[12] : 8'hxx, 8'hE7);
        check("to_err_sticky", err, 1);
`endif

        // graceful stop
        @(posedge PCLK); #1; enable = 0;
        for (int i = 0; i < 100 && running !== 0; i++) @(negedge PCLK);
        check("stop_running", running, 0);
        check("stop_ctrl_addr", wl_a[$], BASE + 32'h100);
        check("stop_ctrl_data", wl_d[$], 0);
        repeat (10) @(negedge PCLK);
        check("stop_idle_psel", PSEL, 0);

        // re-enable reruns init
        w0 = wl_a.size();
        @(posedge PCLK); #1; enable = 1;
        for (int i = 0; i < 200 && running !== 1; i++) @(negedge PCLK);
        check("reinit_running", running, 1);
        check("reinit_count", wl_a.size() - w0, 5);
        for (int k = 0; k < 5 && w0 + k < wl_a.size(); k++) begin
            check("reinit_addr", wl_a[w0 + k], INIT_A[k]);
            check("reinit_data", wl_d[w0 + k], INIT_D[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
